// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for a single MAC cell.
// Accepts a dot-product command of length N and streams N operand pairs into
// the cell. It closes the accumulation loop through acc_out -> acc_in, waits
// for the cell pipeline to drain, and then offers the 32-bit sum on a
// valid/ready result port.
// Optional stall timeout: define MAC_SEQ_TIMEOUT_EN to enable it.
module mac_seq_ctrl #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [15:0]      op_a_i,
  input  logic [15:0]      op_b_i,
  output logic [15:0]      mac_a_o,
  output logic [15:0]      mac_b_o,
  output logic [31:0]      mac_acc_in_o,
  input  logic [31:0]      mac_acc_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             err_o
);

  localparam int unsigned DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
`endif

  // State and datapath registers with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drn_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
      stall_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
`ifdef MAC_SEQ_TIMEOUT_EN
      stall_q     <= stall_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic: command capture, pair counting, drain timing, result handshake.
  // NOTE: every signal gets a hold-value default before the case statement, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drn_d       = drn_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
`ifdef MAC_SEQ_TIMEOUT_EN
    stall_d     = stall_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d   = len_i;
          drn_d   = '0;
`ifdef MAC_SEQ_TIMEOUT_EN
          stall_d = '0;
`endif
          state_d = (len_i != '0) ? S_RUN : S_DRAIN;
        end
      end
      S_RUN: begin
        if (op_valid_i) begin
          cnt_d = cnt_q - LEN_W'(1);
`ifdef MAC_SEQ_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q == LEN_W'(1)) begin
            drn_d   = '0;
            state_d = S_DRAIN;
          end
        end
`ifdef MAC_SEQ_TIMEOUT_EN
        else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          // Abort: report an empty result flagged as an error.
          res_data_d  = '0;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = S_OUT;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end
      S_DRAIN: begin
        // The last product needs MAC_LAT edges to reach acc_out.
        if (drn_q == DRN_W'(MAC_LAT - 1)) begin
          res_data_d  = mac_acc_out_i;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_OUT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Cell drive: operands only in RUN with a valid pair; feedback loop closed in RUN/DRAIN.
  always_comb begin
    op_ready_o   = (state_q == S_RUN);
    mac_a_o      = ((state_q == S_RUN) && op_valid_i) ? op_a_i : 16'h0000;
    mac_b_o      = ((state_q == S_RUN) && op_valid_i) ? op_b_i : 16'h0000;
    mac_acc_in_o = ((state_q == S_RUN) || (state_q == S_DRAIN)) ? mac_acc_out_i : 32'h0;
    busy_o       = (state_q != S_IDLE);
    res_valid_o  = res_valid_q;
    res_data_o   = res_data_q;
`ifdef MAC_SEQ_TIMEOUT_EN
    err_o        = err_q;
`else
    err_o        = 1'b0;
`endif
  end

endmodule
